// File: rtl/dcache_sram_nway.sv
// N-way set-associative data cache array with LRU replacement and dirty victims.
// Optional writeback-invalidate flush sweep, enabled by macro DCACHE_FLUSH_EN.
//
// Ports:
//   clk_i, rst_i         rising-edge clock, asynchronous active-high reset
//   req_i, we_i          request strobe (taken when rdy_o=1), 1=write / 0=read
//   idx_i, tag_i         set index and request tag
//   data_i, dirty_i      write/fill line data, dirty flag to OR into the line
//   flush_i              start a writeback-invalidate sweep (DCACHE_FLUSH_EN only)
//   rdy_o                request may be accepted this cycle
//   hit_o, data_o        registered hit flag and read-hit data (0 otherwise)
//   victim_vld_o         one-cycle pulse with dirty line in victim_tag_o/victim_data_o
//   flush_busy_o         sweep in progress (FLUSH or DONE)
//   flush_done_o         one-cycle pulse when the sweep finishes
module dcache_sram_nway #(
    parameter int SETS   = 16,
    parameter int WAYS   = 4,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [$clog2(SETS)-1:0] idx_i,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [LINE_W-1:0]       data_i,
    input  logic                    dirty_i,
    input  logic                    flush_i,
    output logic                    rdy_o,
    output logic                    hit_o,
    output logic [LINE_W-1:0]       data_o,
    output logic                    victim_vld_o,
    output logic [TAG_W-1:0]        victim_tag_o,
    output logic [LINE_W-1:0]       victim_data_o,
    output logic                    flush_busy_o,
    output logic                    flush_done_o
);

    localparam int IW = $clog2(SETS);
    localparam int AW = $clog2(WAYS);

    // Per-entry state. Ages form a permutation of 0..WAYS-1 per set;
    // age WAYS-1 marks the least recently used way.
    logic              val_q [SETS][WAYS];
    logic              dty_q [SETS][WAYS];
    logic [AW-1:0]     age_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q [SETS][WAYS];
    logic [LINE_W-1:0] dat_q [SETS][WAYS];

    // Registered outputs
    logic              hit_q,   hit_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              vvld_q,  vvld_d;
    logic [TAG_W-1:0]  vtag_q,  vtag_d;
    logic [LINE_W-1:0] vdata_q, vdata_d;

    // Sweep visit of one (set,way) entry
    logic          visit;
    logic [IW-1:0] vis_set;
    logic [AW-1:0] vis_way;

`ifdef DCACHE_FLUSH_EN
    localparam int PW = IW + AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Pointer is {set, way}, so incrementing walks set-major.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                    ptr_d   = '0;
                end
            end
            S_FLUSH: begin
                ptr_d = ptr_q + PW'(1);
                if (ptr_q == {PW{1'b1}}) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign visit        = (state_q == S_FLUSH);
    assign vis_set      = ptr_q[PW-1:AW];
    assign vis_way      = ptr_q[AW-1:0];
    assign rdy_o        = (state_q != S_FLUSH);
    assign flush_busy_o = (state_q != S_IDLE);
    assign flush_done_o = (state_q == S_DONE);
`else
    logic flush_unused;
    assign flush_unused = flush_i;

    assign visit        = 1'b0;
    assign vis_set      = '0;
    assign vis_way      = '0;
    assign rdy_o        = 1'b1;
    assign flush_busy_o = 1'b0;
    assign flush_done_o = 1'b0;
`endif

    // Lookup in the addressed set
    logic            acc;
    logic [WAYS-1:0] hit_vec;
    logic            hit;
    logic            inv_found;
    logic [AW-1:0]   hit_way;
    logic [AW-1:0]   inv_way;
    logic [AW-1:0]   lru_way;
    logic [AW-1:0]   fill_way;
    logic [AW-1:0]   tgt_way;
    logic            upd;
    logic            wr;
    logic            req_vic;
    logic            vis_vic;

    assign acc = req_i & rdy_o;

    always_comb begin
        hit_vec   = '0;
        hit_way   = '0;
        inv_way   = '0;
        inv_found = 1'b0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = val_q[idx_i][w] && (tag_q[idx_i][w] == tag_i);
            if (hit_vec[w]) begin
                hit_way = AW'(w);
            end
            if (age_q[idx_i][w] == AW'(WAYS - 1)) begin
                lru_way = AW'(w);
            end
        end
        // Scan downwards so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!val_q[idx_i][w]) begin
                inv_found = 1'b1;
                inv_way   = AW'(w);
            end
        end
    end

    assign hit      = |hit_vec;
    assign fill_way = inv_found ? inv_way : lru_way;
    assign tgt_way  = hit ? hit_way : fill_way;
    assign upd      = acc & (hit | we_i);
    assign wr       = acc & we_i;
    assign req_vic  = wr & ~hit
                    & val_q[idx_i][fill_way] & dty_q[idx_i][fill_way];
    assign vis_vic  = visit
                    & val_q[vis_set][vis_way] & dty_q[vis_set][vis_way];

    // Valid, dirty and age state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    val_q[s][w] <= 1'b0;
                    dty_q[s][w] <= 1'b0;
                    age_q[s][w] <= AW'(w);
                end
            end
        end else begin
            if (upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == tgt_way) begin
                        age_q[idx_i][w] <= '0;
                    end else if (age_q[idx_i][w] < age_q[idx_i][tgt_way]) begin
                        age_q[idx_i][w] <= age_q[idx_i][w] + AW'(1);
                    end
                end
            end
            if (wr) begin
                val_q[idx_i][tgt_way] <= 1'b1;
                dty_q[idx_i][tgt_way] <= hit ? (dty_q[idx_i][tgt_way] | dirty_i)
                                             : dirty_i;
            end
            if (visit) begin
                val_q[vis_set][vis_way] <= 1'b0;
                dty_q[vis_set][vis_way] <= 1'b0;
            end
        end
    end

    // Tag and data storage carries no reset; valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (wr) begin
            tag_q[idx_i][tgt_way] <= tag_i;
            dat_q[idx_i][tgt_way] <= data_i;
        end
    end

    // Request and sweep are never active together, so victims share one port.
    always_comb begin
        hit_d   = acc & hit;
        rdata_d = '0;
        vvld_d  = req_vic | vis_vic;
        vtag_d  = '0;
        vdata_d = '0;
        if (acc && !we_i && hit) begin
            rdata_d = dat_q[idx_i][hit_way];
        end
        if (req_vic) begin
            vtag_d  = tag_q[idx_i][fill_way];
            vdata_d = dat_q[idx_i][fill_way];
        end else if (vis_vic) begin
            vtag_d  = tag_q[vis_set][vis_way];
            vdata_d = dat_q[vis_set][vis_way];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q   <= 1'b0;
            rdata_q <= '0;
            vvld_q  <= 1'b0;
            vtag_q  <= '0;
            vdata_q <= '0;
        end else begin
            hit_q   <= hit_d;
            rdata_q <= rdata_d;
            vvld_q  <= vvld_d;
            vtag_q  <= vtag_d;
            vdata_q <= vdata_d;
        end
    end

    assign hit_o         = hit_q;
    assign data_o        = rdata_q;
    assign victim_vld_o  = vvld_q;
    assign victim_tag_o  = vtag_q;
    assign victim_data_o = vdata_q;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Randomized self-checking bench for dcache_sram_nway.
// Reference keeps a per-set recency list (MRU first) instead of ages.
module tb_dcache_sram_nway;

    localparam int SETS   = 16;
    localparam int WAYS   = 4;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 256;
    localparam int IW     = $clog2(SETS);

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_i = 1'b0;
    logic              we_i = 1'b0;
    logic [IW-1:0]     idx_i = '0;
    logic [TAG_W-1:0]  tag_i = '0;
    logic [LINE_W-1:0] data_i = '0;
    logic              dirty_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              rdy_o;
    logic              hit_o;
    logic [LINE_W-1:0] data_o;
    logic              victim_vld_o;
    logic [TAG_W-1:0]  victim_tag_o;
    logic [LINE_W-1:0] victim_data_o;
    logic              flush_busy_o;
    logic              flush_done_o;

    dcache_sram_nway #(
        .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .we_i(we_i),
        .idx_i(idx_i), .tag_i(tag_i),
        .data_i(data_i), .dirty_i(dirty_i),
        .flush_i(flush_i), .rdy_o(rdy_o),
        .hit_o(hit_o), .data_o(data_o),
        .victim_vld_o(victim_vld_o),
        .victim_tag_o(victim_tag_o),
        .victim_data_o(victim_data_o),
        .flush_busy_o(flush_busy_o),
        .flush_done_o(flush_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    // Reference model
    bit                m_val [SETS][WAYS];
    bit                m_dty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag [SETS][WAYS];
    logic [LINE_W-1:0] m_dat [SETS][WAYS];
    int                order [SETS][WAYS];

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int p = 0; p < WAYS; p++) begin
                m_val[s][p] = 0;
                m_dty[s][p] = 0;
                order[s][p] = p;
            end
    endfunction

    function automatic void touch(input int s, input int w);
        int p = 0;
        for (int q = 0; q < WAYS; q++) if (order[s][q] == w) p = q;
        for (int q = p; q > 0; q--) order[s][q] = order[s][q-1];
        order[s][0] = w;
    endfunction

    function automatic void model_req(
        input bit we, input int s, input logic [TAG_W-1:0] tag,
        input logic [LINE_W-1:0] d, input bit dty,
        output logic eh, output logic [LINE_W-1:0] ed,
        output logic ev, output logic [TAG_W-1:0] et,
        output logic [LINE_W-1:0] evd);
        int hw = -1;
        int fw = -1;
        eh = 0; ed = '0; ev = 0; et = '0; evd = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_val[s][w] && m_tag[s][w] == tag) hw = w;
        eh = (hw >= 0);
        if (!we) begin
            if (hw >= 0) begin
                ed = m_dat[s][hw];
                touch(s, hw);
            end
        end else if (hw >= 0) begin
            m_dat[s][hw] = d;
            m_dty[s][hw] = m_dty[s][hw] | dty;
            touch(s, hw);
        end else begin
            for (int w = WAYS - 1; w >= 0; w--) if (!m_val[s][w]) fw = w;
            if (fw < 0) fw = order[s][WAYS-1];
            if (m_val[s][fw] && m_dty[s][fw]) begin
                ev = 1; et = m_tag[s][fw]; evd = m_dat[s][fw];
            end
            m_val[s][fw] = 1;
            m_dty[s][fw] = dty;
            m_tag[s][fw] = tag;
            m_dat[s][fw] = d;
            touch(s, fw);
        end
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic op(input bit we, input int s, input logic [TAG_W-1:0] tag,
                      input logic [LINE_W-1:0] d, input bit dty);
        logic eh, ev;
        logic [LINE_W-1:0] ed, evd;
        logic [TAG_W-1:0] et;
        chk("rdy", rdy_o, 1);
        model_req(we, s, tag, d, dty, eh, ed, ev, et, evd);
        req_i = 1; we_i = we; idx_i = s[IW-1:0];
        tag_i = tag; data_i = d; dirty_i = dty;
        @(posedge clk_i); #1;
        req_i = 0; we_i = 0;
        chk("hit", hit_o, eh);
        chk("data", data_o, ed);
        chk("vvld", victim_vld_o, ev);
        chk("vtag", victim_tag_o, et);
        chk("vdata", victim_data_o, evd);
    endtask

    task automatic do_reset();
        rst_i = 1; #1;
        chk("rst_hit", hit_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_vvld", victim_vld_o, 0);
        chk("rst_vtag", victim_tag_o, 0);
        chk("rst_vdata", victim_data_o, 0);
        chk("rst_busy", flush_busy_o, 0);
        chk("rst_done", flush_done_o, 0);
        chk("rst_rdy", rdy_o, 1);
        @(posedge clk_i); #1;
        rst_i = 0;
        model_reset();
    endtask

`ifdef DCACHE_FLUSH_EN
    // Flush starts at the first edge; optional request shares that edge.
    task automatic sweep(input bit wr, input bit we, input int s,
                         input logic [TAG_W-1:0] tag,
                         input logic [LINE_W-1:0] d, input bit dty,
                         input int exp_pulses);
        logic eh, ev;
        logic [LINE_W-1:0] ed, evd;
        logic [TAG_W-1:0] et;
        logic [TAG_W-1:0] qt[$];
        logic [LINE_W-1:0] qd[$];
        int n_rdy0 = 0;
        int n_pulse = 0;
        int n_done = 0;
        int done_at = -1;
        if (wr) model_req(we, s, tag, d, dty, eh, ed, ev, et, evd);
        for (int ss = 0; ss < SETS; ss++)
            for (int w = 0; w < WAYS; w++)
                if (m_val[ss][w] && m_dty[ss][w]) begin
                    qt.push_back(m_tag[ss][w]);
                    qd.push_back(m_dat[ss][w]);
                end
        flush_i = 1;
        if (wr) begin
            req_i = 1; we_i = we; idx_i = s[IW-1:0];
            tag_i = tag; data_i = d; dirty_i = dty;
        end
        for (int k = 0; k < 66; k++) begin
            @(posedge clk_i); #1;
            if (k == 0) begin
                flush_i = 0; req_i = 0; we_i = 0;
                chk("f_busy0", flush_busy_o, 1);
                if (wr) begin
                    chk("f_hit", hit_o, eh);
                    chk("f_data", data_o, ed);
                    chk("f_rvvld", victim_vld_o, ev);
                    chk("f_rvtag", victim_tag_o, et);
                end else begin
                    chk("f_vvld0", victim_vld_o, 0);
                end
            end else if (victim_vld_o) begin
                n_pulse++;
                if (qt.size() > 0) begin
                    chk("f_vtag", victim_tag_o, qt.pop_front());
                    chk("f_vdata", victim_data_o, qd.pop_front());
                end else begin
                    chk("f_vextra", victim_vld_o, 0);
                end
            end
            if (k == 30) flush_i = 1;
            if (k == 33) flush_i = 0;
            if (!rdy_o) n_rdy0++;
            if (flush_done_o) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
        end
        chk("f_rdy0", n_rdy0, 64);
        chk("f_done_at", done_at, 64);
        chk("f_ndone", n_done, 1);
        chk("f_vleft", qt.size(), 0);
        chk("f_idle_busy", flush_busy_o, 0);
        chk("f_idle_rdy", rdy_o, 1);
        if (exp_pulses >= 0) chk("f_npulse", n_pulse, exp_pulses);
        for (int ss = 0; ss < SETS; ss++)
            for (int w = 0; w < WAYS; w++) begin
                m_val[ss][w] = 0;
                m_dty[ss][w] = 0;
            end
    endtask
`endif

    logic [LINE_W-1:0] a5;
    logic [LINE_W-1:0] ln [3];
    int done_seen;

    initial begin
        a5 = {(LINE_W/8){8'hA5}};
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();

        // Write then read back, and a miss on a neighbouring tag
        op(1, 3, 23'h10, a5, 0);
        op(0, 3, 23'h10, '0, 0);
        chk("r27_data", data_o, a5);
        op(0, 3, 23'h11, '0, 0);
        chk("r27_miss", hit_o, 0);

        // Dirty LRU eviction
        for (int t = 1; t <= 4; t++) op(1, 5, TAG_W'(t), rnd_line(), 1);
        op(0, 5, 23'd1, '0, 0);
        op(1, 5, 23'd5, rnd_line(), 1);
        chk("r28_vvld", victim_vld_o, 1);
        chk("r28_vtag", victim_tag_o, 2);

        // Clean eviction produces no victim
        for (int t = 1; t <= 4; t++) op(1, 6, TAG_W'(t), rnd_line(), 0);
        op(0, 6, 23'd1, '0, 0);
        op(1, 6, 23'd5, rnd_line(), 0);
        chk("r29_vvld", victim_vld_o, 0);
        op(0, 6, 23'd5, '0, 0);
        chk("r29_hit", hit_o, 1);
        op(0, 6, 23'd2, '0, 0);
        chk("r29_gone", hit_o, 0);

`ifndef DCACHE_FLUSH_EN
        flush_i = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            chk("nf_busy", flush_busy_o, 0);
            chk("nf_done", flush_done_o, 0);
            chk("nf_rdy", rdy_o, 1);
        end
        op(0, 3, 23'h10, '0, 0);
        flush_i = 0;
        chk("nf_hit", hit_o, 1);
`endif

        // Random traffic concentrated on a few sets and tags
        for (int n = 0; n < 400; n++) begin
            int s;
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, SETS - 1)
                                            : $urandom_range(0, 3);
            op(bit'($urandom_range(0, 1)), s, TAG_W'($urandom_range(0, 6)),
               rnd_line(), bit'($urandom_range(0, 1)));
        end

`ifdef DCACHE_FLUSH_EN
        // Clean sweep with three dirty lines
        do_reset();
        for (int i = 0; i < 3; i++) ln[i] = rnd_line();
        op(1, 0, 23'h21, ln[0], 1);
        op(1, 7, 23'h22, ln[1], 1);
        op(1, 15, 23'h23, ln[2], 1);
        op(1, 7, 23'h24, rnd_line(), 0);
        sweep(0, 0, 0, '0, '0, 0, 3);
        op(0, 0, 23'h21, '0, 0);
        op(0, 7, 23'h22, '0, 0);
        op(0, 7, 23'h24, '0, 0);
        op(0, 15, 23'h23, '0, 0);

        // Request in the same cycle as flush_i
        for (int n = 0; n < 40; n++)
            op(1, $urandom_range(0, SETS - 1), TAG_W'($urandom_range(0, 6)),
               rnd_line(), bit'($urandom_range(0, 1)));
        sweep(1, 1, 9, 23'h33, rnd_line(), 1, -1);
        op(0, 9, 23'h33, '0, 0);

        // Reset during the sweep
        op(1, 2, 23'h41, rnd_line(), 1);
        op(1, 4, 23'h42, rnd_line(), 1);
        flush_i = 1;
        @(posedge clk_i); #1;
        flush_i = 0;
        repeat (19) @(posedge clk_i);
        #1;
        chk("r31_busy", flush_busy_o, 1);
        do_reset();
        done_seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk_i); #1;
            if (flush_done_o || flush_busy_o) done_seen++;
        end
        chk("r31_nodone", done_seen, 0);
        op(0, 2, 23'h41, '0, 0);
        op(0, 4, 23'h42, '0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
